// File: rtl/eth_reg_initiator.sv
// eth_reg_initiator: serialises single register writes/reads from a
// command/response stream onto the Ethernet interface register port.
// Every read wait is bounded, because unmapped addresses never answer.
// Optional boot-time programming of MAC/IP/UDP/mask: ETH_REG_BOOT_INIT_EN.
module eth_reg_initiator #(
    parameter int unsigned REG_AWIDTH = 14,
    parameter int unsigned BASE       = 0,
    parameter int unsigned TIMEOUT    = 16,
    parameter logic [47:0] BOOT_MAC   = 48'h00802f16c52f,
    parameter logic [31:0] BOOT_IP    = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [15:0] BOOT_UDP   = 16'd49153
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_wr,
    input  logic [REG_AWIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_data,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [31:0]           rsp_data,
    output logic [1:0]            rsp_status,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  reg_wr_req,
    output logic [REG_AWIDTH-1:0] reg_wr_addr,
    output logic [31:0]           reg_wr_data,
    output logic                  reg_rd_req,
    output logic [REG_AWIDTH-1:0] reg_rd_addr,
    input  logic                  reg_rd_resp,
    input  logic [31:0]           reg_rd_data,
    output logic                  boot_done
);

    localparam int unsigned         CNT_W   = 8;
    localparam logic [CNT_W-1:0]    TO_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_WR_ACK = 2'b00;
    localparam logic [1:0] ST_RD_OK  = 2'b01;
    localparam logic [1:0] ST_RD_TO  = 2'b10;

    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_WR      = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_RSP     = 3'd5;

`ifdef ETH_REG_BOOT_INIT_EN
    localparam logic [2:0] S_BOOT     = 3'd0;
    localparam logic [2:0] S_RESET    = S_BOOT;
    localparam logic [2:0] BOOT_WRITES = 3'd5;
`else
    localparam logic [2:0] S_RESET    = S_IDLE;
`endif

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  boot_done_q, boot_done_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_data_q, rsp_data_d;
    logic [1:0]            rsp_status_q, rsp_status_d;
    logic                  reg_wr_req_q, reg_wr_req_d;
    logic [REG_AWIDTH-1:0] reg_wr_addr_q, reg_wr_addr_d;
    logic [31:0]           reg_wr_data_q, reg_wr_data_d;
    logic                  reg_rd_req_q, reg_rd_req_d;
    logic [REG_AWIDTH-1:0] reg_rd_addr_q, reg_rd_addr_d;
`ifdef ETH_REG_BOOT_INIT_EN
    logic [2:0]            boot_idx_q, boot_idx_d;
`endif

    // Next-state and next-output logic; all outputs are registered copies of *_d.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        boot_done_d   = boot_done_q;
        cmd_ready_d   = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_status_d  = rsp_status_q;
        reg_wr_req_d  = 1'b0;
        reg_wr_addr_d = reg_wr_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        reg_rd_req_d  = 1'b0;
        reg_rd_addr_d = reg_rd_addr_q;
`ifdef ETH_REG_BOOT_INIT_EN
        boot_idx_d    = boot_idx_q;
`endif
        case (state_q)
`ifdef ETH_REG_BOOT_INIT_EN
            S_BOOT: begin
                if (boot_idx_q == BOOT_WRITES) begin
                    state_d     = S_IDLE;
                    boot_done_d = 1'b1;
                    cmd_ready_d = 1'b1;
                end else begin
                    reg_wr_req_d = 1'b1;
                    boot_idx_d   = boot_idx_q + 3'd1;
                    case (boot_idx_q)
                        3'd0: begin
                            reg_wr_addr_d = REG_AWIDTH'(BASE + 32'h0000);
                            reg_wr_data_d = BOOT_MAC[31:0];
                        end
                        3'd1: begin
                            reg_wr_addr_d = REG_AWIDTH'(BASE + 32'h0004);
                            reg_wr_data_d = {16'h0000, BOOT_MAC[47:32]};
                        end
                        3'd2: begin
                            reg_wr_addr_d = REG_AWIDTH'(BASE + 32'h1000);
                            reg_wr_data_d = BOOT_IP;
                        end
                        3'd3: begin
                            reg_wr_addr_d = REG_AWIDTH'(BASE + 32'h1004);
                            reg_wr_data_d = {16'h0000, BOOT_UDP};
                        end
                        default: begin
                            reg_wr_addr_d = REG_AWIDTH'(BASE + 32'h0008);
                            reg_wr_data_d = 32'h0000_0001;
                        end
                    endcase
                end
            end
`endif
            S_IDLE: begin
                if (!boot_done_q) begin
                    boot_done_d = 1'b1;
                    cmd_ready_d = 1'b1;
                end else if (cmd_valid && cmd_ready_q) begin
                    if (cmd_wr) begin
                        state_d       = S_WR;
                        reg_wr_req_d  = 1'b1;
                        reg_wr_addr_d = cmd_addr;
                        reg_wr_data_d = cmd_data;
                    end else begin
                        state_d       = S_RD_REQ;
                        reg_rd_req_d  = 1'b1;
                        reg_rd_addr_d = cmd_addr;
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            S_WR: begin
                state_d      = S_RSP;
                rsp_valid_d  = 1'b1;
                rsp_data_d   = reg_wr_data_q;
                rsp_status_d = ST_WR_ACK;
            end
            S_RD_REQ: begin
                state_d = S_RD_WAIT;
                cnt_d   = '0;
            end
            S_RD_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response landing on the timeout cycle still counts as a hit.
                if (reg_rd_resp) begin
                    state_d      = S_RSP;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = reg_rd_data;
                    rsp_status_d = ST_RD_OK;
                end else if (cnt_d == TO_LAST) begin
                    state_d      = S_RSP;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = 32'h0;
                    rsp_status_d = ST_RD_TO;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_RESET;
            cnt_q         <= '0;
            boot_done_q   <= 1'b0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_status_q  <= '0;
            reg_wr_req_q  <= 1'b0;
            reg_wr_addr_q <= '0;
            reg_wr_data_q <= '0;
            reg_rd_req_q  <= 1'b0;
            reg_rd_addr_q <= '0;
`ifdef ETH_REG_BOOT_INIT_EN
            boot_idx_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            boot_done_q   <= boot_done_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_status_q  <= rsp_status_d;
            reg_wr_req_q  <= reg_wr_req_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            reg_rd_req_q  <= reg_rd_req_d;
            reg_rd_addr_q <= reg_rd_addr_d;
`ifdef ETH_REG_BOOT_INIT_EN
            boot_idx_q    <= boot_idx_d;
`endif
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_status  = rsp_status_q;
    assign reg_wr_req  = reg_wr_req_q;
    assign reg_wr_addr = reg_wr_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign reg_rd_req  = reg_rd_req_q;
    assign reg_rd_addr = reg_rd_addr_q;
    assign boot_done   = boot_done_q;

endmodule

// File: tb/tb_eth_reg_initiator.sv
// Self-checking bench for eth_reg_initiator: scoreboard of expected
// responses (status, data, arrival cycle) plus a delayed-response register model.
// Boot-sequence checks are compiled in when ETH_REG_BOOT_INIT_EN is defined.
module tb_eth_reg_initiator;

    localparam int unsigned AW = 14;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [31:0]   rsp_data;
    logic [1:0]    rsp_status;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          reg_wr_req;
    logic [AW-1:0] reg_wr_addr;
    logic [31:0]   reg_wr_data;
    logic          reg_rd_req;
    logic [AW-1:0] reg_rd_addr;
    logic          reg_rd_resp;
    logic [31:0]   reg_rd_data;
    logic          boot_done;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   stray_req  = 0;
    int   stray_done = 0;

    eth_reg_initiator #(
        .REG_AWIDTH (AW),
        .BASE       (0),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_wr      (cmd_wr),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .rsp_data    (rsp_data),
        .rsp_status  (rsp_status),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .reg_wr_req  (reg_wr_req),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_req  (reg_rd_req),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_resp (reg_rd_resp),
        .reg_rd_data (reg_rd_data),
        .boot_done   (boot_done)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_req"},   64'(reg_wr_req),  64'd0);
        check({tag, "_rd_req"},   64'(reg_rd_req),  64'd0);
        check({tag, "_cmd_rdy"},  64'(cmd_ready),   64'd0);
        check({tag, "_rsp_vld"},  64'(rsp_valid),   64'd0);
        check({tag, "_boot"},     64'(boot_done),   64'd0);
        check({tag, "_rsp_data"}, 64'(rsp_data),    64'd0);
        check({tag, "_rsp_st"},   64'(rsp_status),  64'd0);
        check({tag, "_wr_addr"},  64'(reg_wr_addr), 64'd0);
        check({tag, "_wr_data"},  64'(reg_wr_data), 64'd0);
        check({tag, "_rd_addr"},  64'(reg_rd_addr), 64'd0);
    endtask

    // Issue one command from the drive phase; returns in the drive phase two cycles after acceptance+1.
    task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data,
                        input logic [1:0] est, input logic [31:0] edata, input int lat,
                        output int acc);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_data  = data;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", 64'(cmd_ready), 64'd1);
        acc = cyc;
        if (cmd_ready) sb.push_back('{est, edata, acc + lat});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        if (wr) begin
            check("wr_req",      64'(reg_wr_req),  64'd1);
            check("wr_addr",     64'(reg_wr_addr), 64'(addr));
            check("wr_data",     64'(reg_wr_data), 64'(data));
            check("rd_req_idle", 64'(reg_rd_req),  64'd0);
        end else begin
            check("rd_req",      64'(reg_rd_req),  64'd1);
            check("rd_addr",     64'(reg_rd_addr), 64'(addr));
            check("wr_req_idle", 64'(reg_wr_req),  64'd0);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("wr_req_1cyc", 64'(reg_wr_req), 64'd0);
        check("rd_req_1cyc", 64'(reg_rd_req), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || rsp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

`ifdef ETH_REG_BOOT_INIT_EN
    // Called in the drive phase of the release cycle (cycle 0).
    task automatic boot_seq();
        logic [AW-1:0] ea [5];
        logic [31:0]   ed [5];
        int r, acc;
        ea[0] = 14'h0000; ed[0] = 32'h2f16c52f;
        ea[1] = 14'h0004; ed[1] = 32'h0000_0080;
        ea[2] = 14'h1000; ed[2] = 32'hC0A8_010A;
        ea[3] = 14'h1004; ed[3] = 32'h0000_C001;
        ea[4] = 14'h0008; ed[4] = 32'h0000_0001;
        r = cyc;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 14'h0200;
        cmd_data  = 32'hB007_0001;
        @(negedge clk);
        check("boot_c0_wr", 64'(reg_wr_req), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("boot_wr_req",  64'(reg_wr_req),  64'd1);
            check("boot_wr_addr", 64'(reg_wr_addr), 64'(ea[i]));
            check("boot_wr_data", 64'(reg_wr_data), 64'(ed[i]));
            check("boot_done_lo", 64'(boot_done),   64'd0);
            check("boot_cmd_rdy", 64'(cmd_ready),   64'd0);
            check("boot_no_rsp",  64'(rsp_valid),   64'd0);
        end
        @(posedge clk);
        #1;
        send(1'b1, 14'h0200, 32'hB007_0001, 2'b00, 32'hB007_0001, 2, acc);
        check("boot_accept_cyc", 64'(acc), 64'(r + 6));
        check("boot_done_hi", 64'(boot_done), 64'd1);
    endtask
`endif

    // Register model: mapped addresses answer after a fixed delay, others stay silent.
    initial begin : responder
        reg_rd_resp = 1'b0;
        reg_rd_data = 32'h0;
        forever begin
            @(negedge clk);
            if (reset_n && reg_rd_req) begin
                int          dly;
                logic [31:0] val;
                dly = 0;
                val = 32'h0;
                case (reg_rd_addr)
                    14'h1004: begin dly = 1;      val = 32'h0000_C001; end
                    14'h0100: begin dly = TO - 1; val = 32'hA5A5_0100; end
                    14'h0104: begin dly = TO;     val = 32'h5A5A_0104; end
                    default:  dly = 0;
                endcase
                if (dly > 0) begin
                    repeat (dly) @(posedge clk);
                    #1;
                    reg_rd_resp = 1'b1;
                    reg_rd_data = val;
                    @(posedge clk);
                    #1;
                    reg_rd_resp = 1'b0;
                    reg_rd_data = 32'hDEAD_BEEF;
                end
            end else if (stray_req != stray_done) begin
                @(posedge clk);
                #1;
                reg_rd_resp = 1'b1;
                reg_rd_data = 32'h1234_5678;
                @(posedge clk);
                #1;
                reg_rd_resp = 1'b0;
                stray_done++;
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response, checks hold under backpressure.
    initial begin : monitor
        logic        prev_valid, prev_ready;
        logic [31:0] prev_data;
        logic [1:0]  prev_status;
        exp_t        e;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_data  = 32'h0;
        prev_status = 2'b00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (reg_wr_req || reg_rd_req)
                    check("strobe_excl", 64'(reg_wr_req & reg_rd_req), 64'd0);
                if (prev_valid && !prev_ready) begin
                    check("rsp_hold_valid",  64'(rsp_valid),  64'd1);
                    check("rsp_hold_data",   64'(rsp_data),   64'(prev_data));
                    check("rsp_hold_status", 64'(rsp_status), 64'(prev_status));
                    check("rsp_cmd_ready",   64'(cmd_ready),  64'd0);
                end else if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_status", 64'(rsp_status), 64'(e.st));
                        check("rsp_data",   64'(rsp_data),   64'(e.data));
                        check("rsp_cycle",  64'(cyc),        64'(e.due));
                        check("rsp_cmd_rdy", 64'(cmd_ready), 64'd0);
                    end
                end
                prev_valid  = rsp_valid;
                prev_ready  = rsp_ready;
                prev_data   = rsp_data;
                prev_status = rsp_status;
            end
        end
    end

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int acc, acc2, h, n;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
`ifdef ETH_REG_BOOT_INIT_EN
        boot_seq();
        drain();
`else
        @(negedge clk);
        check("boot_done_rel", 64'(boot_done), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("boot_done_1st", 64'(boot_done),  64'd1);
        check("cmd_ready_1st", 64'(cmd_ready),  64'd1);
        check("no_boot_write", 64'(reg_wr_req), 64'd0);
        @(posedge clk);
        #1;
`endif

        // Write of the IP register, then a mapped read with 1-cycle responder.
        send(1'b1, 14'h1000, 32'hC0A8_0164, 2'b00, 32'hC0A8_0164, 2, acc);
        drain();
        send(1'b0, 14'h1004, 32'h0, 2'b01, 32'h0000_C001, 3, acc);
        check("wr_addr_hold", 64'(reg_wr_addr), 64'h1000);
        check("wr_data_hold", 64'(reg_wr_data), 64'hC0A8_0164);
        drain();

        // Unmapped read times out; a stray response afterwards is ignored.
        send(1'b0, 14'h0FF0, 32'h0, 2'b10, 32'h0, TO + 1, acc);
        drain();
        stray_req++;
        repeat (4) begin
            @(negedge clk);
            check("stray_idle_rdy", 64'(cmd_ready), 64'd1);
            @(posedge clk);
            #1;
        end

        // Response on the last wait cycle wins; one cycle later is too late.
        send(1'b0, 14'h0100, 32'h0, 2'b01, 32'hA5A5_0100, TO + 1, acc);
        drain();
        send(1'b0, 14'h0104, 32'h0, 2'b10, 32'h0, TO + 1, acc);
        drain();

        // Back-to-back: next command accepted the cycle after the handshake.
        send(1'b0, 14'h1004, 32'h0, 2'b01, 32'h0000_C001, 3, acc);
        send(1'b1, 14'h0008, 32'h1, 2'b00, 32'h1, 2, acc2);
        check("b2b_accept_cyc", 64'(acc2), 64'(acc + 4));
        drain();

        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] a;
            logic [31:0]   d;
            a = 14'($urandom_range(0, 16383));
            d = $urandom;
            send(1'b1, a, d, 2'b00, d, 2, acc);
            drain();
        end

        // Backpressure with a second command pending.
        rsp_ready = 1'b0;
        send(1'b1, 14'h0004, 32'h0000_0080, 2'b00, 32'h0000_0080, 2, acc);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 14'h1004;
        cmd_data  = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        h = cyc;
        send(1'b0, 14'h1004, 32'h0, 2'b01, 32'h0000_C001, 3, acc2);
        check("bp_accept_cyc", 64'(acc2), 64'(h + 1));
        drain();

        // Reset on the read-strobe cycle aborts without a response.
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 14'h1004;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_accept", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("abort_rd_req", 64'(reg_rd_req), 64'd1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (TO + 8) begin
            @(negedge clk);
            check("abort_no_rd", 64'(reg_rd_req), 64'd0);
            @(posedge clk);
            #1;
        end

        send(1'b1, 14'h1004, 32'h0000_C002, 2'b00, 32'h0000_C002, 2, acc);
        drain();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_reg_initiator.md
# eth_reg_initiator

Register-port initiator that drives the Ethernet interface configuration registers (MAC, IP, UDP port, MAC mask) from a simple command/response stream. It sits between the control processor's command path and the Ethernet interface's register write/read port. It serialises one register access at a time, and it bounds every read with a timeout because the responder never responds to unmapped addresses. An optional boot sequence programs the addressing registers right after reset.

## Interface
- `REG_AWIDTH`, 14, register address width.
- `BASE`, 0, base offset of the Ethernet register block.
- `TIMEOUT`, 16, read-response wait limit in cycles (≥2, ≤255).
- `BOOT_MAC`, 48'h00802f16c52f, MAC written by boot sequence.
- `BOOT_IP`, {8'd192,8'd168,8'd1,8'd10}, IP written by boot sequence.
- `BOOT_UDP`, 16'd49153, UDP port written by boot sequence.

Ports:
- `clk`  in  1  single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_wr`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  REG_AWIDTH  register address.
- `cmd_data`  in  32  write data (ignored on read).
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake.
- `rsp_data`  out  32  read data, or echoed write data.
- `rsp_status`  out  2  00 write ack, 01 read ok, 10 read timeout.
- `rsp_valid` / `rsp_ready`  out/in  1  response handshake.
- `reg_wr_req`  out  1  write strobe.
- `reg_wr_addr`  out  REG_AWIDTH  write address.
- `reg_wr_data`  out  32  write data.
- `reg_rd_req`  out  1  read strobe.
- `reg_rd_addr`  out  REG_AWIDTH  read address.
- `reg_rd_resp`  in  1  read response strobe.
- `reg_rd_data`  in  32  read data.
- `boot_done`  out  1  boot complete; commands accepted only when high.

## Operation
- States: BOOT, IDLE, WR, RD_REQ, RD_WAIT, RSP.
- BOOT: exists only with the macro; otherwise reset exits directly to IDLE.
- IDLE:
  - `cmd_ready`=1 only in IDLE with `boot_done`=1.
  - On `cmd_valid && cmd_ready`, latch `cmd_*` and go to WR or RD_REQ.
- WR:
  - `reg_wr_req`=1 for exactly one cycle, with the latched address and data.
  - Then RSP with status 00 and `rsp_data`=written data.
- RD_REQ:
  - `reg_rd_req`=1 for exactly one cycle.
  - Clear the wait counter, then go to RD_WAIT.
- RD_WAIT:
  - The counter increments each cycle.
  - If `reg_rd_resp` is seen: capture `reg_rd_data` and go to RSP with status 01.
  - Else, when the counter reaches TIMEOUT-1: go to RSP with status 10 and data 0.
  - If the response and the timeout occur in the same cycle, the response wins (status 01).
- RSP:
  - `rsp_valid`=1, with data and status held stable until `rsp_ready`; then IDLE.
  - `cmd_ready`=0 throughout.
- `reg_rd_resp` outside RD_WAIT is ignored.
- `reg_*_addr`/`reg_*_data` hold their last values between strobes.
- `reg_wr_req` and `reg_rd_req` are never high together.

## Timing
- Reset values:
  - all strobes, `cmd_ready`, `rsp_valid` and `boot_done` = 0;
  - `rsp_data`, `rsp_status`, `reg_*_addr` and `reg_*_data` = 0.
- Reset assertion mid-access:
  - aborts immediately;
  - any in-flight strobe drops asynchronously;
  - no response is produced.
- Write: accept at cycle 0, `reg_wr_req` at cycle 1, `rsp_valid` at cycle 2.
- Read, with the responder's 1-cycle latency: accept at cycle 0, `reg_rd_req` at cycle 1, `reg_rd_resp` sampled at cycle 2, `rsp_valid` at cycle 3.
- Read timeout: `rsp_valid` at cycle 1+TIMEOUT.
- Throughput is one access in flight. With `rsp_ready` held high, the next command is accepted the cycle after the response handshake.

## Configuration
- Macro: `ETH_REG_BOOT_INIT_EN`.
- Defined: after `reset_n` deasserts, BOOT issues five writes on consecutive cycles 1–5, one `reg_wr_req` each:
  - BASE+0x0000 ← BOOT_MAC[31:0]
  - BASE+0x0004 ← {16'b0, BOOT_MAC[47:32]}
  - BASE+0x1000 ← BOOT_IP
  - BASE+0x1004 ← {16'b0, BOOT_UDP}
  - BASE+0x0008 (MAC mask) ← 32'h1
- Defined, completion:
  - No responses are generated for boot writes.
  - `boot_done` rises at cycle 6; IDLE follows.
  - Addresses are truncated to REG_AWIDTH.
- Undefined:
  - No BOOT state.
  - `boot_done`=1 from the first clock after reset release.
  - No register access occurs until a command arrives.

## Test plan
- Write BASE+0x1000 ← 0xC0A80164, `rsp_ready`=1:
  - `reg_wr_req` one cycle with that address/data;
  - response status 00, data 0xC0A80164, at cycle 2.
- Read BASE+0x1004, responder returns 0x0000C001 one cycle after the request:
  - response status 01, data 0x0000C001, at cycle 3.
- Read unmapped address 0x0FF0, responder silent, TIMEOUT=16:
  - response status 10, data 0, at cycle 17;
  - a stray `reg_rd_resp` injected in IDLE afterwards produces no response.
- Response backpressure: hold `rsp_ready`=0 for 10 cycles with a second `cmd_valid` pending:
  - `rsp_*` stable and `cmd_ready`=0 throughout;
  - second command accepted the cycle after `rsp_ready` rises.
- With `ETH_REG_BOOT_INIT_EN`:
  - five writes on cycles 1–5 in the listed order with default values;
  - `boot_done` at cycle 6;
  - no `rsp_valid`;
  - `cmd_valid` held from cycle 0 is accepted at cycle 6.
- Assert `reset_n`=0 on the `reg_rd_req` cycle:
  - strobe drops immediately and all outputs take reset values;
  - after release, no response is emitted for the aborted read.
